// File: rtl/eeprom_port_arbiter_if.sv
// Bundled requester-side and EEPROM-side handshake of the EEPROM port arbiter.
// The slave modport is the arbiter's view; master is the requesters' and EEPROM's view.
interface eeprom_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  localparam int GW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*ADDR_W-1:0] Req_Address;
  logic [NUM_REQ*DATA_W-1:0] Req_WrData;
  logic [NUM_REQ-1:0]        Req_RdLatch;
  logic [NUM_REQ-1:0]        Req_WrLatch;
  logic [NUM_REQ*DATA_W-1:0] Req_RdData;
  logic [NUM_REQ-1:0]        Req_Busy;
  logic [ADDR_W-1:0]         EEPROM_Address;
  logic [DATA_W-1:0]         EEPROM_WrData;
  logic                      EEPROM_RdLatch;
  logic                      EEPROM_WrLatch;
  logic [DATA_W-1:0]         EEPROM_RdData;
  logic                      EEPROM_Busy;
  logic [GW-1:0]             Grant;

  modport slave (
    input  Req_Address, Req_WrData, Req_RdLatch, Req_WrLatch, EEPROM_RdData, EEPROM_Busy,
    output Req_RdData, Req_Busy, EEPROM_Address, EEPROM_WrData, EEPROM_RdLatch,
           EEPROM_WrLatch, Grant
  );

  modport master (
    output Req_Address, Req_WrData, Req_RdLatch, Req_WrLatch, EEPROM_RdData, EEPROM_Busy,
    input  Req_RdData, Req_Busy, EEPROM_Address, EEPROM_WrData, EEPROM_RdLatch,
           EEPROM_WrLatch, Grant
  );
endinterface

// File: rtl/eeprom_port_arbiter.sv
// Round-robin sharing of one EEPROM byte port between NUM_REQ requesters, one cycle in flight.
// Define EEPROM_ARB_TIMEOUT_EN to add a watchdog that aborts stuck cycles and pulses Timeout.
module eeprom_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic Clk,
  input  logic nReset,
`ifdef EEPROM_ARB_TIMEOUT_EN
  output logic Timeout,
`endif
  eeprom_port_arbiter_if.slave bus
);
  localparam int GW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

  // state | meaning
  // IDLE  | EEPROM free, arbitrate among pending requesters
  // ISSUE | latch presented, waiting for EEPROM_Busy to rise
  // WAIT  | EEPROM working, waiting for EEPROM_Busy to fall
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state;
  logic [GW-1:0]       ptr, grant, win, cand, nextPtr;
  logic                found, isWr, rdLatch, wrLatch, tmoHit;
  logic [NUM_REQ-1:0]  pending, busyQ;
  logic [ADDR_W-1:0]   addrQ;
  logic [DATA_W-1:0]   wrDataQ;
  logic [ADDR_W-1:0]   reqAddr   [NUM_REQ];
  logic [DATA_W-1:0]   reqWrData [NUM_REQ];
  logic [DATA_W-1:0]   rdData    [NUM_REQ];

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : gBadParam
    $error("eeprom_port_arbiter: parameter out of range");
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
    assign reqAddr[g]   = bus.Req_Address[g*ADDR_W +: ADDR_W];
    assign reqWrData[g] = bus.Req_WrData[g*DATA_W +: DATA_W];
    assign bus.Req_RdData[g*DATA_W +: DATA_W] = rdData[g];
  end

  assign pending = bus.Req_RdLatch | bus.Req_WrLatch;
  assign nextPtr = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GW'((int'(ptr) + i) % NUM_REQ);
      if (!found && pending[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef EEPROM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign tmoHit = (state != IDLE) && (cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt     <= '0;
      Timeout <= 1'b0;
    end else begin
      Timeout <= tmoHit;
      if (state == IDLE || tmoHit || (state == ISSUE && bus.EEPROM_Busy) ||
          (state == WAIT && !bus.EEPROM_Busy))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmoHit = 1'b0;
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      isWr    <= 1'b0;
      rdLatch <= 1'b0;
      wrLatch <= 1'b0;
      busyQ   <= '0;
      addrQ   <= '0;
      wrDataQ <= '0;
      for (int i = 0; i < NUM_REQ; i++) rdData[i] <= '0;
    end else if (tmoHit) begin
      rdLatch <= 1'b0;
      wrLatch <= 1'b0;
      busyQ   <= '0;
      ptr     <= nextPtr;
      state   <= IDLE;
    end else begin
      case (state)
        IDLE: if (!bus.EEPROM_Busy && found) begin
          grant   <= win;
          addrQ   <= reqAddr[win];
          wrDataQ <= reqWrData[win];
          // Write wins when both latches are raised.
          isWr    <= bus.Req_WrLatch[win];
          wrLatch <= bus.Req_WrLatch[win];
          rdLatch <= ~bus.Req_WrLatch[win];
          busyQ   <= NUM_REQ'(1) << win;
          state   <= ISSUE;
        end
        ISSUE: if (bus.EEPROM_Busy) begin
          rdLatch <= 1'b0;
          wrLatch <= 1'b0;
          state   <= WAIT;
        end
        WAIT: if (!bus.EEPROM_Busy) begin
          if (!isWr) rdData[grant] <= bus.EEPROM_RdData;
          busyQ <= '0;
          ptr   <= nextPtr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Req_Busy       = busyQ;
  assign bus.EEPROM_Address = addrQ;
  assign bus.EEPROM_WrData  = wrDataQ;
  assign bus.EEPROM_RdLatch = rdLatch;
  assign bus.EEPROM_WrLatch = wrLatch;
  assign bus.Grant          = grant;
endmodule

// File: tb/tb_eeprom_port_arbiter.sv
// Scoreboard bench for eeprom_port_arbiter: requester drivers push expectations, an EEPROM
// model and a completion monitor pop and compare them. Covers the timeout when EEPROM_ARB_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_eeprom_port_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 8;

  typedef struct packed { logic wr; logic [15:0] a; logic [7:0] d; } iss_t;
  typedef struct packed { logic upd; logic [15:0] a; } done_t;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  int checks = 0;
  int errors = 0;

  iss_t  issQ  [NREQ][$];
  done_t doneQ [NREQ][$];
  int    grantLog[$];
  bit    eeAuto = 0, logOn = 0, rndTiming = 0;
  int    riseDly = 1, busyLen = 5;
  logic [7:0] lastRd [NREQ];
  logic [NREQ-1:0] prevBusy = '0;

  eeprom_port_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef EEPROM_ARB_TIMEOUT_EN
  logic Timeout;
  eeprom_port_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .nReset(nReset), .Timeout(Timeout), .bus(bus));
`else
  eeprom_port_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .nReset(nReset), .bus(bus));
`endif

  always #5 Clk = ~Clk;

  // Content the EEPROM model returns for any address.
  function automatic logic [7:0] romData(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [44:0] allOutputs();
    return {bus.Req_Busy, bus.Req_RdData, bus.EEPROM_RdLatch, bus.EEPROM_WrLatch,
            bus.EEPROM_Address, bus.EEPROM_WrData, bus.Grant};
  endfunction

  task automatic clearQueues();
    for (int r = 0; r < NREQ; r++) begin
      issQ[r].delete();
      doneQ[r].delete();
    end
  endtask

  task automatic applyReset();
    @(negedge Clk);
    nReset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    nReset = 1'b1;
    clearQueues();
  endtask

  // One requester transaction following the Req_Busy handshake.
  task automatic txn(input int r, input bit wr, input bit both, input logic [15:0] a,
                     input logic [7:0] d, input bit tmo);
    int t;
    @(negedge Clk);
    t = 0;
    while (bus.Req_Busy[r] && t < 500) begin @(negedge Clk); t++; end
    bus.Req_Address[r*16 +: 16] = a;
    bus.Req_WrData[r*8 +: 8]    = d;
    bus.Req_WrLatch[r]          = wr;
    bus.Req_RdLatch[r]          = !wr || both;
    issQ[r].push_back('{wr: wr, a: a, d: d});
    doneQ[r].push_back('{upd: !wr && !tmo, a: a});
    t = 0;
    do begin @(negedge Clk); t++; end while (!bus.Req_Busy[r] && t < 500);
    check("req_busy_rise", bus.Req_Busy[r], 1'b1);
    bus.Req_WrLatch[r] = 1'b0;
    bus.Req_RdLatch[r] = 1'b0;
    t = 0;
    while (bus.Req_Busy[r] && t < 500) begin @(negedge Clk); t++; end
    check("req_busy_fall", bus.Req_Busy[r], 1'b0);
  endtask

  task automatic rndTxn(input int r);
    txn(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 16'($urandom), 8'($urandom), 0);
  endtask

  // EEPROM model: consumes each issued cycle and checks it against the requester's expectation.
  initial begin : eeModel
    iss_t e;
    int g;
    logic [15:0] a;
    forever begin
      @(negedge Clk);
      if (eeAuto && nReset && (bus.EEPROM_RdLatch || bus.EEPROM_WrLatch)) begin
        g = int'(bus.Grant);
        a = bus.EEPROM_Address;
        if (logOn) grantLog.push_back(g);
        if (issQ[g].size() == 0) check("ee_unexpected_cycle", 1'b1, 1'b0);
        else begin
          e = issQ[g].pop_front();
          check("ee_request",
                {bus.EEPROM_RdLatch, bus.EEPROM_WrLatch, a, e.wr ? bus.EEPROM_WrData : 8'h00},
                {~e.wr, e.wr, e.a, e.wr ? e.d : 8'h00});
        end
        if (rndTiming) begin
          riseDly = $urandom_range(0, 2);
          busyLen = $urandom_range(1, 4);
        end
        repeat (riseDly) @(negedge Clk);
        bus.EEPROM_Busy   = 1'b1;
        bus.EEPROM_RdData = 8'($urandom);
        repeat (busyLen) @(negedge Clk);
        bus.EEPROM_RdData = romData(a);
        bus.EEPROM_Busy   = 1'b0;
      end
    end
  end

  // Completion monitor: on each Req_Busy fall, check that requester's read data.
  initial begin : doneMon
    done_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (!nReset) begin
        prevBusy = '0;
        for (int r = 0; r < NREQ; r++) lastRd[r] = 8'h00;
      end else begin
        for (int r = 0; r < NREQ; r++) begin
          if (prevBusy[r] && !bus.Req_Busy[r]) begin
            if (doneQ[r].size() == 0) check("done_unexpected", 1'b1, 1'b0);
            else begin
              e = doneQ[r].pop_front();
              if (e.upd) lastRd[r] = romData(e.a);
              check("req_rd_data", bus.Req_RdData[r*8 +: 8], lastRd[r]);
            end
          end
        end
        prevBusy = bus.Req_Busy;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

  initial begin : stim
    int t;
    logic seen;
    logic [15:0] seq;
    bus.Req_Address = '0; bus.Req_WrData = '0; bus.Req_RdLatch = '0; bus.Req_WrLatch = '0;
    bus.EEPROM_RdData = '0; bus.EEPROM_Busy = 1'b0;
    #12;
    check("reset_outputs", allOutputs(), 45'h0);
    @(negedge Clk);
    nReset = 1'b1;

    // Single read by requester 0.
    eeAuto = 1; riseDly = 1; busyLen = 5;
    fork
      txn(0, 0, 0, 16'h0400, 8'h00, 0);
      begin
        t = 0;
        do begin @(posedge Clk); t++; end while (!bus.Req_RdLatch[0] && t < 50);
        @(negedge Clk);
        check("read_latency", {bus.EEPROM_RdLatch, bus.EEPROM_WrLatch, bus.EEPROM_Address,
                               bus.Req_Busy, bus.Grant}, {1'b1, 1'b0, 16'h0400, 2'b01, 1'b0});
      end
    join
    check("read_data_a5", bus.Req_RdData, {8'h00, 8'hA5});

    // Simultaneous requests from reset alternate strictly.
    applyReset();
    logOn = 1;
    fork
      begin txn(0, 0, 0, 16'h0010, 8'h00, 0); txn(0, 0, 0, 16'h0020, 8'h00, 0); end
      begin txn(1, 0, 0, 16'h0100, 8'h00, 0); txn(1, 1, 0, 16'h0200, 8'h77, 0); end
    join
    logOn = 0;
    seq = '0;
    foreach (grantLog[k]) seq = {seq[11:0], 4'(grantLog[k])};
    check("grant_sequence", {grantLog.size(), seq}, {32'd4, 16'h0101});

    // Write held off while the EEPROM is busy internally.
    eeAuto = 0;
    bus.EEPROM_Busy = 1'b1;
    fork
      txn(1, 1, 0, 16'h1234, 8'h5A, 0);
      begin
        seen = 1'b0;
        repeat (4) begin @(negedge Clk); seen |= bus.EEPROM_RdLatch | bus.EEPROM_WrLatch; end
        check("no_latch_while_busy", seen, 1'b0);
        bus.EEPROM_Busy = 1'b0;
        @(negedge Clk);
        check("write_issue", {bus.EEPROM_RdLatch, bus.EEPROM_WrLatch, bus.EEPROM_Address,
                              bus.EEPROM_WrData, bus.Grant}, {1'b0, 1'b1, 16'h1234, 8'h5A, 1'b1});
        bus.EEPROM_Busy = 1'b1;
        repeat (2) @(negedge Clk);
        bus.EEPROM_Busy = 1'b0;
      end
    join
    clearQueues();

    // Both latches raised: write only, read data kept.
    eeAuto = 1;
    txn(0, 1, 1, 16'h0055, 8'hC3, 0);
    check("both_latch_rd_kept", bus.Req_RdData[7:0], romData(16'h0020));

    // Reset while in WAIT.
    eeAuto = 0;
    fork
      txn(0, 0, 0, 16'h0222, 8'h00, 0);
      begin
        t = 0;
        do begin @(negedge Clk); t++; end while (!bus.EEPROM_RdLatch && t < 50);
        bus.EEPROM_Busy = 1'b1;
        repeat (2) @(negedge Clk);
        nReset = 1'b0;
        #1;
        check("reset_in_wait", allOutputs(), 45'h0);
        bus.EEPROM_Busy = 1'b0;
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
      end
    join
    clearQueues();
    eeAuto = 1;
    txn(1, 0, 0, 16'h00F0, 8'h00, 0);
    check("after_reset_grant", bus.Grant, 1'b1);

`ifdef EEPROM_ARB_TIMEOUT_EN
    // EEPROM never answers: the watchdog frees the port.
    eeAuto = 0;
    check("timeout_reset_low", Timeout, 1'b0);
    fork
      txn(0, 0, 0, 16'h0777, 8'h00, 1);
      begin
        t = 0;
        do begin @(negedge Clk); t++; end while (!bus.EEPROM_RdLatch && t < 50);
        t = 0;
        do begin @(negedge Clk); t++; end while (!Timeout && t < 100);
        check("timeout_delay", t, 17);
        @(negedge Clk);
        check("timeout_pulse", {Timeout, bus.Req_Busy, bus.EEPROM_RdLatch}, 4'b0000);
      end
    join
    clearQueues();
    eeAuto = 1;
    txn(1, 0, 0, 16'h0123, 8'h00, 0);
`endif

    // Randomized traffic from both requesters.
    rndTiming = 1;
    fork
      for (int k = 0; k < 25; k++) begin repeat ($urandom_range(0, 3)) @(negedge Clk); rndTxn(0); end
      for (int k = 0; k < 25; k++) begin repeat ($urandom_range(0, 3)) @(negedge Clk); rndTxn(1); end
    join
    repeat (5) @(negedge Clk);
    check("queues_drained", issQ[0].size() + issQ[1].size() + doneQ[0].size() + doneQ[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eeprom_port_arbiter.md
Name: eeprom_port_arbiter

Overview:
Shares the single EEPROM byte port (address, read/write latch, busy handshake) between NUM_REQ requesters, e.g. the CPU cache and a loader/debug master. Each requester sees a private copy of the EEPROM handshake, so it can be connected unchanged. Arbitration is round-robin, with one transaction in flight at a time.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ADDR_W, 16, EEPROM address width
DATA_W, 8, EEPROM data width
TIMEOUT_CYCLES, 1024, watchdog limit; used only with EEPROM_ARB_TIMEOUT_EN

Ports:
nReset  in  1  asynchronous, active-low reset
Clk  in  1  clock; all logic on posedge
Req_Address  in  NUM_REQ*ADDR_W  per-requester address; slice i = requester i
Req_WrData  in  NUM_REQ*DATA_W  per-requester write data
Req_RdLatch  in  NUM_REQ  per-requester read request
Req_WrLatch  in  NUM_REQ  per-requester write request
Req_RdData  out  NUM_REQ*DATA_W  per-requester registered read data
Req_Busy  out  NUM_REQ  per-requester busy
EEPROM_Address  out  ADDR_W  to EEPROM
EEPROM_WrData  out  DATA_W  to EEPROM
EEPROM_RdLatch  out  1  to EEPROM
EEPROM_WrLatch  out  1  to EEPROM
EEPROM_RdData  in  DATA_W  from EEPROM
EEPROM_Busy  in  1  from EEPROM
Grant  out  clog2(NUM_REQ) max 1  index of the current or last owner

Behaviour:
- Reset: all outputs 0. State IDLE. Round-robin pointer 0, so requester 0 has first priority.
- Requester protocol:
  - Raise RdLatch or WrLatch while its Req_Busy=0.
  - Hold the latch, address and data until Req_Busy=1, then drop the latch.
  - The transaction is complete when Req_Busy returns to 0. Req_RdData is valid from that cycle and holds until the next read completes for that requester.
- Pending(i) = Req_RdLatch[i] | Req_WrLatch[i]. If both latches are set, the request is a write and the read is ignored.
- States:
  - IDLE:
    - If EEPROM_Busy=1, wait.
    - Else, if any request is pending, pick the first pending index at or after the pointer, with wrap-around.
    - Register Grant, EEPROM_Address, EEPROM_WrData and op type (rd/wr).
    - Set EEPROM_RdLatch or EEPROM_WrLatch, set Req_Busy[winner]=1, go to ISSUE.
  - ISSUE: when EEPROM_Busy=1, clear both EEPROM latches and go to WAIT.
  - WAIT: when EEPROM_Busy=0:
    - For a read, capture EEPROM_RdData into Req_RdData[Grant].
    - Clear Req_Busy[Grant], set pointer = Grant+1 (mod NUM_REQ), go to IDLE.
- Latency: the latch reaches the EEPROM 1 clock after the request is sampled in IDLE. Req_Busy falls in the same edge as the data capture.
- There is at least one IDLE cycle between transactions. Back-to-back requests from several masters alternate strictly.
- Non-granted requesters keep Req_Busy=0 and their requests stay pending. Request inputs are not sampled outside IDLE.
- Req_Busy is one-hot or zero. Only Req_RdData[Grant] ever changes.
- A latch dropped by a requester before it is granted withdraws the request with no side effects.
- Reset mid-transaction returns everything to the reset values immediately. Any EEPROM cycle in progress is abandoned, and the arbiter does not wait for EEPROM_Busy.

Optional Feature:
EEPROM_ARB_TIMEOUT_EN:
- Defined:
  - A counter runs in ISSUE and WAIT, cleared on every state change.
  - On reaching TIMEOUT_CYCLES, clear the EEPROM latches and Req_Busy[Grant], and leave Req_RdData unchanged.
  - Pulse the extra output port Timeout (1 bit, reset 0) high for one cycle, advance the pointer and go to IDLE.
- Undefined: no counter and no Timeout port. ISSUE and WAIT wait indefinitely.

Test Plan:
1. Req0 read at 16'h0400, EEPROM model returns 8'hA5 after 5 busy cycles -> EEPROM_RdLatch 1 clock after the request, EEPROM_Address=16'h0400, Req_Busy[0] high throughout, Req_RdData[0]=8'hA5 when Req_Busy[0] falls; Req1 outputs unchanged.
2. Req0 and Req1 both request in the same cycle from reset -> Req0 served first, then Req1; with both re-requesting continuously, Grant sequence is 0,1,0,1.
3. Req1 write 16'h1234/8'h5A while EEPROM_Busy=1 (internal write in progress) -> no latch until EEPROM_Busy=0; then EEPROM_WrLatch=1, EEPROM_WrData=8'h5A.
4. Req0 asserts RdLatch and WrLatch together -> EEPROM_WrLatch only, Req_RdData[0] unchanged.
5. nReset asserted during WAIT -> all outputs 0 that cycle; after release, a new Req1 read completes normally with the pointer at 0.
6. (macro defined, TIMEOUT_CYCLES=16) EEPROM_Busy never rises -> Timeout pulses 17 cycles after the latch, Req_Busy returns to 0, and the next request is served.
